dice_roll_sampler: RTL
======================

// Module: dice_roll_sampler
// PURPOSE
//  Consumer end of the GARO entropy path. Gates the ring oscillator through osc_en,
//  samples its synchronised random bit and von-Neumann debiases it. Assembles
//  unbiased bits into a die value by rejection sampling and returns one roll per request.
//  Runs a repetition-count health test on raw samples. Sits between GARO and the
//  dice display/control logic.
// PARAMETERS
//  NUM_SIDES   6    die faces; roll_value range 1..NUM_SIDES (2..256)
//  SAMPLE_DIV  16   clk cycles per raw sample of random (>=2)
//  WARMUP_CYC  256  cycles osc runs before first sample is used (>=1)
//  REP_LIMIT   32   consecutive identical raw samples that declare a fault (>=2)
//  VAL_W       $clog2(NUM_SIDES), localparam, width of assembled value
// PORTS
//  clk         in   1      system clock
//  reset       in   1      synchronous, active-high reset
//  random      in   1      synchronised GARO output bit (already double-flopped)
//  roll_req    in   1      1-cycle request pulse; honoured only in IDLE
//  fault_clr   in   1      clears sticky fault, returns to IDLE
//  osc_en      out  1      drives GARO stop input; 1 = oscillate
//  busy        out  1      high in WARMUP/COLLECT/CHECK
//  roll_valid  out  1      1-cycle pulse, roll_value updated same cycle
//  roll_value  out  8      result 1..NUM_SIDES, held until next roll_valid
//  fault       out  1      sticky health-test failure
// BEHAVIOUR
//  Reset: state IDLE; osc_en, busy, roll_valid, fault = 0; roll_value = 0; all counters 0.
//  FSM states (registered, one transition max per cycle):
//   IDLE    osc_en=0. roll_req -> WARMUP, clear warmup/sample/rep counters.
//   WARMUP  osc_en=1. Count WARMUP_CYC cycles, samples discarded -> COLLECT.
//   COLLECT osc_en=1. Sample strobe when sample counter == SAMPLE_DIV-1, then wraps to 0.
//           Raw samples taken in pairs: 01->bit 0, 10->bit 1, 00/11->discard pair.
//           Accepted bits shift into acc MSB-first. After VAL_W bits -> CHECK.
//   CHECK   acc < NUM_SIDES: roll_value <= acc+1, roll_valid=1 -> DONE.
//           Otherwise clear acc and bit count, keep pair phase reset -> COLLECT.
//           Osc stays enabled. No retry limit; a stuck source is caught by the health test.
//   DONE    one cycle, osc_en=0 -> IDLE. roll_req here is ignored, with no queueing.
//   FAULT   osc_en=0, fault=1 (sticky). fault_clr -> IDLE; roll_req ignored.
//  Health test: in COLLECT only, rep counter increments when a raw sample equals the
//   previous raw sample, else reloads to 1. Reaching REP_LIMIT -> FAULT next cycle.
//  Simultaneous fault and final bit: fault wins; no roll_valid, roll_value unchanged.
//  fault_clr outside FAULT: no effect. roll_req outside IDLE: no effect.
//  Min latency roll_req->roll_valid: 1 + WARMUP_CYC + 2*VAL_W*SAMPLE_DIV + 1 cycles.
//  Reset mid-operation: immediate return to reset state; partial acc discarded.
//  roll_value zero-extended from VAL_W to 8 bits.
// STRUCTURE
//  Shared header dice_pkg.vh holds the FSM state encodings (IDLE..FAULT, 3 bits) and
//  default NUM_SIDES, SAMPLE_DIV, WARMUP_CYC and REP_LIMIT constants. Display logic reuses these.
//  One sub-module: vn_debias (clk, reset, clr, sample_stb, raw -> bit_valid, bit_out),
//  which holds pair phase and first-of-pair register. Parent owns the FSM, counters,
//  rejection and health test.
// TESTING  (NUM_SIDES=6, SAMPLE_DIV=2, WARMUP_CYC=4, REP_LIMIT=8; bench drives random)
//  1 Reset held 3 cycles, mid-COLLECT -> osc_en=0, busy=0, roll_valid=0, roll_value=0, fault=0.
//  2 roll_req; raw pairs 01,10,10 -> bits 0,1,1 -> acc=3, roll_valid pulse, roll_value=4;
//    latency = 1+4+12+1 = 18 cycles.
//  3 Raw pairs 10,10,10 (acc=7, rejected) then 01,01,10 -> roll_value=2, single roll_valid.
//  4 Raw pairs 00,11,01,10,01 -> two discards, bits 0,1,0 -> roll_value=3.
//  5 random stuck at 1 through 8 samples in COLLECT -> fault=1, osc_en=0, no roll_valid.
//    roll_req ignored; fault_clr -> IDLE, fault=0.
//  6 roll_req pulsed during WARMUP and during DONE -> ignored; exactly one roll_valid per accepted request.

Source files
------------

// File: rtl/dice_roll_sampler_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dice_roll_sampler_pkg : shared FSM encodings and default params  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package dice_roll_sampler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_COLLECT = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DONE    = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  localparam int DEF_NUM_SIDES  = 6;
  localparam int DEF_SAMPLE_DIV = 16;
  localparam int DEF_WARMUP_CYC = 256;
  localparam int DEF_REP_LIMIT  = 32;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dice_roll_sampler_vn_debias.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vn_debias : von Neumann pair debiaser (01->0, 10->1, 00/11 drop)  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module vn_debias (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic sample_stb,
  input  logic raw,
  output logic bit_valid,
  output logic bit_out
);

  logic phase;
  logic first;

  // The accepted bit equals the first sample of a differing pair.
  assign bit_valid = sample_stb && phase && (first != raw) && !clr;
  assign bit_out   = first;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      phase <= 1'b0;
      first <= 1'b0;
    end else if (sample_stb) begin
      phase <= ~phase;
      if (!phase)
        first <= raw;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dice_roll_sampler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dice_roll_sampler : GARO consumer, debiased rejection-sampled die |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module dice_roll_sampler
  import dice_roll_sampler_pkg::*;
#(
  parameter int NUM_SIDES  = DEF_NUM_SIDES,
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int WARMUP_CYC = DEF_WARMUP_CYC,
  parameter int REP_LIMIT  = DEF_REP_LIMIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       random,
  input  logic       roll_req,
  input  logic       fault_clr,
  output logic       osc_en,
  output logic       busy,
  output logic       roll_valid,
  output logic [7:0] roll_value,
  output logic       fault
);

  localparam int VAL_W  = width_of(NUM_SIDES);
  localparam int WARM_W = width_of(WARMUP_CYC);
  localparam int SDIV_W = width_of(SAMPLE_DIV);
  localparam int REP_W  = $clog2(REP_LIMIT + 1);
  localparam int BCNT_W = $clog2(VAL_W + 1);

  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYC - 1);
  localparam logic [SDIV_W-1:0] SDIV_LAST = SDIV_W'(SAMPLE_DIV - 1);
  localparam logic [REP_W-1:0]  REP_TRIP  = REP_W'(REP_LIMIT);
  localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(VAL_W - 1);
  localparam logic [VAL_W:0]    SIDES_C   = (VAL_W + 1)'(NUM_SIDES);

  state_t              state;
  logic [WARM_W-1:0]   warm_cnt;
  logic [SDIV_W-1:0]   sample_cnt;
  logic [REP_W-1:0]    rep_cnt;
  logic                prev_raw;
  logic [BCNT_W-1:0]   bit_cnt;
  logic [VAL_W-1:0]    acc;

  logic                sample_stb;
  logic                deb_clr;
  logic                bit_valid;
  logic                bit_out;
  logic [REP_W-1:0]    rep_next;
  logic                rep_trip;
  logic [VAL_W-1:0]    acc_next;
  logic                acc_ok;
  logic [8:0]          die_val;

  assign sample_stb = (state == ST_COLLECT) && (sample_cnt == SDIV_LAST);
  assign deb_clr    = (state != ST_COLLECT);

  // A zero count marks "no previous sample yet", so the first sample starts a run of one.
  assign rep_next = (rep_cnt != '0 && random == prev_raw) ? rep_cnt + REP_W'(1) : REP_W'(1);
  assign rep_trip = sample_stb && (rep_next == REP_TRIP);

  assign acc_next = VAL_W'({acc, bit_out});
  assign acc_ok   = ({1'b0, acc} < SIDES_C);
  assign die_val  = 9'(acc) + 9'd1;

  vn_debias u_debias (
    .clk        (clk),
    .reset      (reset),
    .clr        (deb_clr),
    .sample_stb (sample_stb),
    .raw        (random),
    .bit_valid  (bit_valid),
    .bit_out    (bit_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      osc_en     <= 1'b0;
      busy       <= 1'b0;
      roll_valid <= 1'b0;
      roll_value <= 8'd0;
      fault      <= 1'b0;
      warm_cnt   <= '0;
      sample_cnt <= '0;
      rep_cnt    <= '0;
      prev_raw   <= 1'b0;
      bit_cnt    <= '0;
      acc        <= '0;
    end else begin
      roll_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (roll_req) begin
            state      <= ST_WARMUP;
            osc_en     <= 1'b1;
            busy       <= 1'b1;
            warm_cnt   <= '0;
            sample_cnt <= '0;
            rep_cnt    <= '0;
            bit_cnt    <= '0;
            acc        <= '0;
          end
        end
        ST_WARMUP: begin
          if (warm_cnt == WARM_LAST) begin
            state      <= ST_COLLECT;
            sample_cnt <= '0;
          end else begin
            warm_cnt <= warm_cnt + WARM_W'(1);
          end
        end
        ST_COLLECT: begin
          sample_cnt <= sample_stb ? '0 : sample_cnt + SDIV_W'(1);
          if (sample_stb) begin
            rep_cnt  <= rep_next;
            prev_raw <= random;
          end
          // A health failure pre-empts a bit completing on the same sample.
          if (rep_trip) begin
            state  <= ST_FAULT;
            osc_en <= 1'b0;
            busy   <= 1'b0;
            fault  <= 1'b1;
          end else if (bit_valid) begin
            acc <= acc_next;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= ST_CHECK;
            end else begin
              bit_cnt <= bit_cnt + BCNT_W'(1);
            end
          end
        end
        ST_CHECK: begin
          if (acc_ok) begin
            roll_value <= die_val[7:0];
            roll_valid <= 1'b1;
            state      <= ST_DONE;
            osc_en     <= 1'b0;
            busy       <= 1'b0;
          end else begin
            acc        <= '0;
            bit_cnt    <= '0;
            sample_cnt <= '0;
            state      <= ST_COLLECT;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        ST_FAULT: begin
          if (fault_clr) begin
            state <= ST_IDLE;
            fault <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          osc_en <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
